// File: rtl/hs_unit_pkg.sv
// Shared types for the handshake register-slice units.
// The skid state encoding doubles as the occupancy count.
package hs_unit_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } hs_skid_state_e;

endpackage

// File: rtl/hs_unit_dff_noreset_ce.sv
// Clock-enable register without reset, generic payload type.
// Holds its value on every edge where ce is low.
module hs_unit_dff_noreset_ce #(
  parameter type DATA_TYPE = logic
) (
  input  logic     clk,
  input  logic     ce,
  input  DATA_TYPE din,
  output DATA_TYPE q
);

  DATA_TYPE data_q;

  always_ff @(posedge clk) begin
    if (ce) begin
      data_q <= din;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/hs_unit_skid_buffer.sv
// Two-entry valid/ready register slice with skid register.
// Breaks valid/ready timing paths at one beat per cycle.
module hs_unit_skid_buffer
  import hs_unit_pkg::*;
#(
  parameter type DATA_TYPE = logic
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  DATA_TYPE   s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output DATA_TYPE   m_data,
  output logic [1:0] occupancy
);

  hs_skid_state_e state_q, state_d;
  logic s_ready_q, s_ready_d;
  logic m_valid_q, m_valid_d;

  logic s_xfer, m_xfer;
  logic load_main, load_skid, sel_skid;

  DATA_TYPE main_din;
  DATA_TYPE main_q;
  DATA_TYPE skid_q;

  assign s_xfer = s_valid & s_ready_q;
  assign m_xfer = m_valid_q & m_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    sel_skid  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (s_xfer) begin
          load_main = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_xfer && m_xfer) begin
          load_main = 1'b1;
        end else if (s_xfer) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (m_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // s_ready is low here, so only the drain can happen
        if (m_xfer) begin
          load_main = 1'b1;
          sel_skid  = 1'b1;
          state_d   = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign s_ready_d = (state_d != FULL);
  assign m_valid_d = (state_d != EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign main_din = sel_skid ? skid_q : s_data;

  hs_unit_dff_noreset_ce #(
    .DATA_TYPE(DATA_TYPE)
  ) u_main (
    .clk (clk),
    .ce  (load_main),
    .din (main_din),
    .q   (main_q)
  );

  hs_unit_dff_noreset_ce #(
    .DATA_TYPE(DATA_TYPE)
  ) u_skid (
    .clk (clk),
    .ce  (load_skid),
    .din (s_data),
    .q   (skid_q)
  );

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_hs_unit_skid_buffer.sv
// Self-checking bench for hs_unit_skid_buffer with a struct payload.
// Scoreboard queue filled on accepts, drained on output transfers.
module tb_hs_unit_skid_buffer;

  typedef struct packed {
    logic [7:0]  tag;
    logic [15:0] value;
  } payload_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  payload_t   s_data;
  logic       m_valid;
  logic       m_ready;
  payload_t   m_data;
  logic [1:0] occupancy;

  int checks = 0;
  int errors = 0;

  payload_t sb[$];

  always #5 clk = ~clk;

  hs_unit_skid_buffer #(
    .DATA_TYPE(payload_t)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  function automatic payload_t mk(input logic [7:0] t);
    payload_t p;
    p.tag   = t;
    p.value = {t, ~t};
    return p;
  endfunction

  // One clock: record handshakes seen at the edge, keep the scoreboard.
  task automatic tick(output bit sx, output bit mx,
                      output payload_t md, output bit have,
                      output payload_t exp);
    sx   = !rst && (s_valid === 1'b1) && (s_ready === 1'b1);
    mx   = !rst && (m_valid === 1'b1) && (m_ready === 1'b1);
    md   = m_data;
    have = 1'b0;
    exp  = '0;
    if (mx && sb.size() > 0) begin
      have = 1'b1;
      exp  = sb.pop_front();
    end
    if (sx) sb.push_back(s_data);
    @(posedge clk);
    #1;
    if (rst) sb.delete();
  endtask

  task automatic test_reset();
    bit sx, mx, have;
    payload_t md, exp;
    rst = 1'b1; s_valid = 1'b1; s_data = mk(8'h11); m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(sx, mx, md, have, exp);
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: m_valid=%b s_ready=%b occ=%0d, want 0 0 0",
                 i, m_valid, s_ready, occupancy);
      end
    end
    rst = 1'b0;
    tick(sx, mx, md, have, exp);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b m_valid=%b, want 1 0",
               s_ready, m_valid);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_single();
    bit sx, mx, have;
    payload_t md, exp;
    m_ready = 1'b0; s_valid = 1'b1; s_data = mk(8'h5A);
    tick(sx, mx, md, have, exp);
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || occupancy !== 2'd1 || m_data !== mk(8'h5A)) begin
      errors++;
      $display("FAIL single_present: m_valid=%b occ=%0d data=%h, want 1 1 %h",
               m_valid, occupancy, m_data, mk(8'h5A));
    end
    m_ready = 1'b1;
    tick(sx, mx, md, have, exp);
    checks++;
    if (!mx || !have || md !== exp || md !== mk(8'h5A)) begin
      errors++;
      $display("FAIL single_xfer: mx=%b data=%h, want 1 %h", mx, md, mk(8'h5A));
    end
    checks++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL single_empty: m_valid=%b occ=%0d, want 0 0",
               m_valid, occupancy);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_streaming();
    bit sx, mx, have;
    payload_t md, exp;
    int outs = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = mk(8'(i));
      tick(sx, mx, md, have, exp);
      checks++;
      if (sx !== 1'b1 || s_ready !== 1'b1 || mx !== (i > 0)) begin
        errors++;
        $display("FAIL stream_flow beat%0d: sx=%b s_ready=%b mx=%b, want 1 1 %b",
                 i, sx, s_ready, mx, i > 0);
      end
      if (mx) begin
        outs++;
        checks++;
        if (!have || md !== exp || md !== mk(8'(i - 1))) begin
          errors++;
          $display("FAIL stream_data beat%0d: got %h want %h",
                   i, md, mk(8'(i - 1)));
        end
      end
    end
    s_valid = 1'b0;
    tick(sx, mx, md, have, exp);
    if (mx) outs++;
    checks++;
    if (!mx || md !== mk(8'd7) || outs != 8 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_tail: mx=%b data=%h outs=%0d m_valid=%b, want 1 %h 8 0",
               mx, md, outs, m_valid, mk(8'd7));
    end
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit sx, mx, have;
    payload_t md, exp;
    payload_t order[3];
    int idx = 0;
    order[0] = mk(8'h0A); order[1] = mk(8'h0B); order[2] = mk(8'h0C);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = order[i];
      tick(sx, mx, md, have, exp);
      checks++;
      if (sx !== (i < 2)) begin
        errors++;
        $display("FAIL bp_accept beat%0d: accepted=%b want %b", i, sx, i < 2);
      end
    end
    checks++;
    if (s_ready !== 1'b0 || occupancy !== 2'd2 || m_data !== order[0]) begin
      errors++;
      $display("FAIL bp_full: s_ready=%b occ=%0d data=%h, want 0 2 %h",
               s_ready, occupancy, m_data, order[0]);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 8 && idx < 3; c++) begin
      tick(sx, mx, md, have, exp);
      if (sx) s_valid = 1'b0;
      if (mx) begin
        checks++;
        if (!have || md !== exp || md !== order[idx]) begin
          errors++;
          $display("FAIL bp_order out%0d: got %h want %h", idx, md, order[idx]);
        end
        idx++;
      end
    end
    tick(sx, mx, md, have, exp);
    checks++;
    if (idx != 3 || mx || m_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: outs=%0d extra=%b m_valid=%b left=%0d, want 3 0 0 0",
               idx, mx, m_valid, sb.size());
    end
    s_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit sx, mx, have;
    payload_t md, exp;
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = mk(8'h71); tick(sx, mx, md, have, exp);
    s_data = mk(8'h72); tick(sx, mx, md, have, exp);
    s_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL midrst_fill: occ=%0d want 2", occupancy);
    end
    rst = 1'b1;
    tick(sx, mx, md, have, exp);
    checks++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: m_valid=%b occ=%0d s_ready=%b, want 0 0 0",
               m_valid, occupancy, s_ready);
    end
    rst = 1'b0;
    tick(sx, mx, md, have, exp);
    s_valid = 1'b1; s_data = mk(8'h33);
    tick(sx, mx, md, have, exp);
    s_valid = 1'b0; m_ready = 1'b1;
    tick(sx, mx, md, have, exp);
    checks++;
    if (!mx || !have || md !== exp || md !== mk(8'h33)) begin
      errors++;
      $display("FAIL midrst_beat: mx=%b data=%h, want 1 %h", mx, md, mk(8'h33));
    end
    tick(sx, mx, md, have, exp);
    checks++;
    if (mx || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_alone: extra output mx=%b m_valid=%b, want 0 0",
               mx, m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_struct_random();
    bit sx, mx, have, pend, stall;
    payload_t md, exp, cur, held;
    pend = 1'b0; cur = '0;
    for (int c = 0; c < 1000; c++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        cur  = payload_t'($urandom);
      end
      s_valid = pend; s_data = cur;
      m_ready = 1'($urandom_range(0, 1));
      stall = (m_valid === 1'b1) && !m_ready;
      held  = m_data;
      tick(sx, mx, md, have, exp);
      if (sx) pend = 1'b0;
      if (mx) begin
        checks++;
        if (!have || md !== exp) begin
          errors++;
          $display("FAIL rand_data cyc%0d: got %h want %h", c, md, exp);
        end
      end
      if (stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          errors++;
          $display("FAIL rand_stall cyc%0d: m_valid=%b data=%h, want 1 %h",
                   c, m_valid, m_data, held);
        end
      end
      checks++;
      if (occupancy !== 2'(sb.size())) begin
        errors++;
        $display("FAIL rand_occ cyc%0d: occ=%0d want %0d", c, occupancy, sb.size());
      end
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(sx, mx, md, have, exp);
      if (mx) begin
        checks++;
        if (!have || md !== exp) begin
          errors++;
          $display("FAIL rand_drain: got %h want %h", md, exp);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_empty: left=%0d m_valid=%b, want 0 0", sb.size(), m_valid);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_reset_mid();
    test_struct_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
